// File: rtl/alu_defs_pkg.sv
// Shared definitions for the ALU execute unit: 5-bit ALU codes, FSM states
// and the alu_op/funct3/funct7 decoder used by the execute stage.
package alu_defs;

    localparam int ALU_CTRL_W = 5;

    typedef logic [ALU_CTRL_W-1:0] alu_ctrl_t;

    localparam alu_ctrl_t ALU_ADD    = 5'd0;
    localparam alu_ctrl_t ALU_SUB    = 5'd1;
    localparam alu_ctrl_t ALU_AND    = 5'd2;
    localparam alu_ctrl_t ALU_OR     = 5'd3;
    localparam alu_ctrl_t ALU_XOR    = 5'd4;
    localparam alu_ctrl_t ALU_SLL    = 5'd5;
    localparam alu_ctrl_t ALU_SRL    = 5'd6;
    localparam alu_ctrl_t ALU_SRA    = 5'd7;
    localparam alu_ctrl_t ALU_SLT    = 5'd8;
    localparam alu_ctrl_t ALU_SLTU   = 5'd9;
    localparam alu_ctrl_t ALU_MUL    = 5'd10;
    localparam alu_ctrl_t ALU_MULH   = 5'd11;
    localparam alu_ctrl_t ALU_MULHSU = 5'd12;
    localparam alu_ctrl_t ALU_MULHU  = 5'd13;
    localparam alu_ctrl_t ALU_DIV    = 5'd14;
    localparam alu_ctrl_t ALU_DIVU   = 5'd15;
    localparam alu_ctrl_t ALU_REM    = 5'd16;
    localparam alu_ctrl_t ALU_REMU   = 5'd17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } alu_state_e;

    // M encodings are laid out in funct3 order starting at ALU_MUL.
    function automatic alu_ctrl_t decode_alu(input logic [1:0] alu_op,
                                             input logic [2:0] funct3,
                                             input logic [6:0] funct7,
                                             input logic       m_ext);
        alu_ctrl_t code;
        code = ALU_ADD;
        if (alu_op == 2'b01) begin
            code = ALU_SUB;
        end else if (alu_op[1]) begin
            if (!alu_op[0] && m_ext && funct7 == 7'b0000001) begin
                code = ALU_MUL + alu_ctrl_t'(funct3);
            end else begin
                case (funct3)
                    3'b000:  code = (!alu_op[0] && funct7[5]) ? ALU_SUB : ALU_ADD;
                    3'b001:  code = ALU_SLL;
                    3'b010:  code = ALU_SLT;
                    3'b011:  code = ALU_SLTU;
                    3'b100:  code = ALU_XOR;
                    3'b101:  code = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  code = ALU_OR;
                    default: code = ALU_AND;
                endcase
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply / restoring-divide datapath: one step per cycle over XLEN
// cycles on sign-stripped operands, with sign-corrected hi/lo/q/r outputs.
module alu_muldiv_iter
    import alu_defs::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            start,
    input  alu_ctrl_t       op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic [XLEN-1:0] q,
    output logic [XLEN-1:0] r
);

    localparam int CW = $clog2(XLEN);

    logic              running_q;
    logic              is_div_q;
    logic              neg_a_q;
    logic              neg_b_q;
    logic [CW-1:0]     count_q;
    logic [2*XLEN-1:0] mcand_q;
    logic [2*XLEN-1:0] prod_q;
    logic [XLEN-1:0]   mplier_q;
    logic [XLEN-1:0]   quo_q;
    logic [XLEN-1:0]   rem_q;
    logic [XLEN-1:0]   divisor_q;

    logic              sign_a;
    logic              sign_b;
    logic              neg_a;
    logic              neg_b;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic [XLEN:0]     shifted;
    logic [XLEN:0]     diff;
    logic [2*XLEN-1:0] prod_fix;

    always_comb begin
        sign_a  = (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHSU) ||
                  (op == ALU_DIV) || (op == ALU_REM);
        sign_b  = (op == ALU_MUL) || (op == ALU_MULH) ||
                  (op == ALU_DIV) || (op == ALU_REM);
        neg_a   = sign_a && a[XLEN-1];
        neg_b   = sign_b && b[XLEN-1];
        abs_a   = neg_a ? (~a + 1'b1) : a;
        abs_b   = neg_b ? (~b + 1'b1) : b;
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, divisor_q};
    end

    // A borrow out of the trial subtraction (diff[XLEN]) means the divisor did not fit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running_q <= 1'b0;
            is_div_q  <= 1'b0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            count_q   <= '0;
            mcand_q   <= '0;
            prod_q    <= '0;
            mplier_q  <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
        end else if (flush) begin
            running_q <= 1'b0;
            count_q   <= '0;
        end else if (start) begin
            running_q <= 1'b1;
            is_div_q  <= (op >= ALU_DIV);
            neg_a_q   <= neg_a;
            neg_b_q   <= neg_b;
            count_q   <= '0;
            mcand_q   <= {{XLEN{1'b0}}, abs_a};
            prod_q    <= '0;
            mplier_q  <= abs_b;
            quo_q     <= abs_a;
            rem_q     <= '0;
            divisor_q <= abs_b;
        end else if (running_q) begin
            if (is_div_q) begin
                if (!diff[XLEN]) begin
                    rem_q <= diff[XLEN-1:0];
                    quo_q <= {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_q <= shifted[XLEN-1:0];
                    quo_q <= {quo_q[XLEN-2:0], 1'b0};
                end
            end else begin
                if (mplier_q[0]) begin
                    prod_q <= prod_q + mcand_q;
                end
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
            end
            if (count_q == CW'(XLEN-1)) begin
                running_q <= 1'b0;
                count_q   <= '0;
            end else begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    always_comb begin
        done     = running_q && (count_q == CW'(XLEN-1));
        prod_fix = (neg_a_q ^ neg_b_q) ? (~prod_q + 1'b1) : prod_q;
        hi       = prod_fix[2*XLEN-1:XLEN];
        lo       = prod_fix[XLEN-1:0];
        q        = (neg_a_q ^ neg_b_q) ? (~quo_q + 1'b1) : quo_q;
        r        = neg_a_q ? (~rem_q + 1'b1) : rem_q;
    end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: decodes alu_op/funct3/funct7, runs base ops in one cycle and
// hands MUL/DIV/REM to the iterative datapath, with valid/ready on both sides.
module alu_exec_unit
    import alu_defs::*;
#(
    parameter int XLEN  = 32,
    parameter bit M_EXT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    alu_state_e      state_q, state_d;
    alu_ctrl_t       code, code_q;
    logic            accept;
    logic            is_mul;
    logic            is_div;
    logic            div_by_zero;
    logic            div_ovf;
    logic            iter_op;
    logic            md_start;
    logic            md_done;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] base_res;
    logic [XLEN-1:0] fix_res;
    logic [XLEN-1:0] md_hi, md_lo, md_q, md_r;

    always_comb begin
        code        = decode_alu(alu_op, funct3, funct7, M_EXT);
        shamt       = op_b[SHW-1:0];
        is_mul      = (code >= ALU_MUL) && (code <= ALU_MULHU);
        is_div      = (code >= ALU_DIV) && (code <= ALU_REMU);
        div_by_zero = (op_b == '0);
        div_ovf     = ((code == ALU_DIV) || (code == ALU_REM)) &&
                      (op_a == MIN_VAL) && (op_b == '1);
        iter_op     = is_mul || (is_div && !div_by_zero && !div_ovf);
        in_ready    = !flush && ((state_q == ST_IDLE) ||
                                 ((state_q == ST_DONE) && out_ready));
        accept      = in_valid && in_ready;
        md_start    = accept && iter_op;
        out_valid   = (state_q == ST_DONE);
        busy        = (state_q == ST_CALC) || (state_q == ST_FIX);
    end

    // Division special cases never reach the iterative path, so their results live here.
    always_comb begin
        base_res = '0;
        case (code)
            ALU_ADD:  base_res = op_a + op_b;
            ALU_SUB:  base_res = op_a - op_b;
            ALU_AND:  base_res = op_a & op_b;
            ALU_OR:   base_res = op_a | op_b;
            ALU_XOR:  base_res = op_a ^ op_b;
            ALU_SLL:  base_res = op_a << shamt;
            ALU_SRL:  base_res = op_a >> shamt;
            ALU_SRA:  base_res = XLEN'($signed(op_a) >>> shamt);
            ALU_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: base_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            ALU_DIV,
            ALU_DIVU: base_res = div_by_zero ? '1 : MIN_VAL;
            ALU_REM,
            ALU_REMU: base_res = div_by_zero ? op_a : '0;
            default:  base_res = '0;
        endcase
    end

    always_comb begin
        fix_res = md_lo;
        case (code_q)
            ALU_MULH,
            ALU_MULHSU,
            ALU_MULHU: fix_res = md_hi;
            ALU_DIV,
            ALU_DIVU:  fix_res = md_q;
            ALU_REM,
            ALU_REMU:  fix_res = md_r;
            default:   fix_res = md_lo;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_CALC: if (md_done) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            state_d = iter_op ? ST_CALC : ST_DONE;
        end
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            code_q <= ALU_ADD;
        end else if (!flush) begin
            if (accept) begin
                code_q <= code;
                if (!iter_op) begin
                    result <= base_res;
                end
            end else if (state_q == ST_FIX) begin
                result <= fix_res;
            end
        end
    end

    alu_muldiv_iter #(
        .XLEN (XLEN)
    ) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .start (md_start),
        .op    (code),
        .a     (op_a),
        .b     (op_b),
        .done  (md_done),
        .hi    (md_hi),
        .lo    (md_lo),
        .q     (md_q),
        .r     (md_r)
    );

endmodule
